conv_output_stage: RTL and testbench

- Downstream consumer of the 3x3 systolic convolution engine.
- Takes the engine's 32-bit signed sum stream and discards the border sums produced before the line buffer holds a full 3x3 window.
- Requantizes the rest to 8-bit pixels: round, arithmetic shift, ReLU or absolute value, then clamp.
- Buffers the result in a small FIFO behind a ready/valid output to the pixel sink or DMA.

---
 rtl/conv_output_stage.sv | 175 +++++++++++++++++
 tb/tb_conv_output_stage.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_output_stage.sv
// Requantizes convolution sums to 8-bit pixels, discarding the 3x3 window border.
// Latency: an input sampled at edge N is written to the output FIFO at edge N+2.
// Backpressure: none upstream; a kept pixel that meets a full FIFO is dropped and flags overflow.
module conv_output_stage #(
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 32,
  parameter int SHIFT      = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [31:0]                   in_sum,
  input  logic                          abs_en,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [7:0]                    out_pixel,
  output logic                          out_last,
  output logic                          frame_done,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic signed [32:0] RND =
    (SHIFT > 0) ? (33'sd1 <<< ((SHIFT > 0) ? SHIFT - 1 : 0)) : 33'sd0;

  typedef struct packed {
    logic       last;
    logic [7:0] pixel;
  } pix_t;

  logic [CW-1:0]      col;
  logic [RW-1:0]      row;
  logic               col_end, row_end, keep_in, last_in;
  logic signed [32:0] sum_rnd;

  logic               s1_vld, s1_keep, s1_last, s1_abs;
  logic signed [32:0] s1_r;
  logic signed [32:0] mag;
  logic [7:0]         pix;

  logic               s2_vld;
  pix_t               s2_dat;
  logic               push_rdy;
  pix_t               head;

  assign col_end = (col == CW'(IMG_WIDTH - 1));
  assign row_end = (row == RW'(IMG_HEIGHT - 1));
  assign keep_in = (row >= RW'(2)) && (col >= CW'(2));
  assign last_in = col_end && row_end;
  // 33-bit sum so adding the rounding constant can never wrap
  assign sum_rnd = $signed({in_sum[31], in_sum}) + RND;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= in_valid && last_in;
      if (in_valid) begin
        if (col_end) begin
          col <= '0;
          row <= row_end ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s1_keep <= 1'b0;
      s1_last <= 1'b0;
      s1_abs  <= 1'b0;
      s1_r    <= '0;
    end else begin
      s1_vld  <= in_valid;
      s1_keep <= keep_in;
      s1_last <= last_in;
      s1_abs  <= abs_en;
      s1_r    <= sum_rnd >>> SHIFT;
    end
  end

  always_comb begin
    mag = s1_r;
    if (s1_r[32]) mag = s1_abs ? -s1_r : 33'sd0;
    pix = (mag > 33'sd255) ? 8'hFF : mag[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_vld   <= 1'b0;
      s2_dat   <= '0;
      overflow <= 1'b0;
    end else begin
      s2_vld <= s1_vld && s1_keep;
      s2_dat <= '{last: s1_last, pixel: pix};
      if (s2_vld && !push_rdy) overflow <= 1'b1;
    end
  end

  conv_fifo #(
    .WIDTH ($bits(pix_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (s2_vld),
    .push_dat (s2_dat),
    .push_rdy (push_rdy),
    .pop_vld  (out_valid),
    .pop_rdy  (out_ready),
    .pop_dat  (head),
    .level    (fifo_level)
  );

  assign out_pixel = head.pixel;
  assign out_last  = head.last;
endmodule

// Show-ahead FIFO; head data reads as zero while empty.
// Latency: a push is visible at the head the cycle after it lands.
// Backpressure: push_rdy low only when full and not popping this cycle.
module conv_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_vld,
  input  logic [WIDTH-1:0]       push_dat,
  output logic                   push_rdy,
  output logic                   pop_vld,
  input  logic                   pop_rdy,
  output logic [WIDTH-1:0]       pop_dat,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             push_fire, pop_fire;

  assign pop_vld   = (level != '0);
  assign pop_fire  = pop_vld && pop_rdy;
  assign push_rdy  = (level != LW'(DEPTH)) || pop_fire;
  assign push_fire = push_vld && push_rdy;
  assign pop_dat   = pop_vld ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_fire) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_fire) rd_ptr <= rd_ptr + AW'(1);
      case ({push_fire, pop_fire})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_output_stage.sv
// Randomized bench for conv_output_stage against a position/arithmetic reference model.
module tb_conv_output_stage;
    localparam int W = 32, H = 32, SH = 4, D = 8;
    localparam int KEPT = (W - 2) * (H - 2);

    logic        clk = 1'b0;
    logic        rst, in_valid, abs_en, out_ready;
    logic [31:0] in_sum;
    logic        out_valid, out_last, frame_done, overflow;
    logic [7:0]  out_pixel;
    logic [3:0]  fifo_level;

    int errors = 0, checks = 0;
    int exp_q[$];       // last*256 + pixel
    int model_idx = 0;  // input index within the frame

    always #5 clk = ~clk;

    conv_output_stage #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .SHIFT(SH), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sum(in_sum), .abs_en(abs_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
        .out_last(out_last), .frame_done(frame_done), .overflow(overflow),
        .fifo_level(fifo_level)
    );

    function automatic int ref_pix(input longint s, input bit a);
        longint r;
        r = (s + (longint'(1) << (SH - 1))) >>> SH;
        if (r < 0) r = a ? -r : 0;
        if (r > 255) r = 255;
        return int'(r);
    endfunction

    task automatic feed(input int sum, input bit a);
        int r, c;
        r = model_idx / W;
        c = model_idx % W;
        if (r >= 2 && c >= 2)
            exp_q.push_back(((r == H - 1 && c == W - 1) ? 256 : 0) + ref_pix(longint'(sum), a));
        model_idx = (model_idx + 1) % (W * H);
        in_valid = 1'b1; in_sum = sum; abs_en = a;
    endtask

    task automatic idle();
        in_valid = 1'b0; in_sum = '0; abs_en = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; idle(); out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        model_idx = 0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({out_valid, out_pixel, out_last, frame_done, overflow, fifo_level} !== '0) begin
            errors++;
            $display("FAIL reset_hold: got v=%b px=%h l=%b fd=%b ov=%b lvl=%0d want all 0",
                     out_valid, out_pixel, out_last, frame_done, overflow, fifo_level);
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || fifo_level !== 4'd0) begin
            errors++;
            $display("FAIL reset_release: got v=%b lvl=%0d want 0 0", out_valid, fifo_level);
        end
        model_idx = 0;
    endtask

    task automatic test_full_frame();
        int n = 0, fd = 0, fd_at = -1;
        out_ready = 1'b1;
        for (int i = 0; i < W * H + 8; i++) begin
            @(negedge clk);
            if (frame_done === 1'b1) begin fd++; fd_at = i; end
            if (out_valid && out_ready) begin
                n++; checks++;
                if (out_pixel !== 8'h03 || out_last !== (n == KEPT)) begin
                    errors++;
                    $display("FAIL frame_pix #%0d: got px=%h last=%b want px=03 last=%b",
                             n, out_pixel, out_last, n == KEPT);
                end
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (i < W * H) feed(40, 1'b0); else idle();
        end
        checks++;
        if (n !== KEPT) begin
            errors++;
            $display("FAIL frame_count: got %0d want %0d", n, KEPT);
        end
        checks++;
        if (fd !== 1 || fd_at !== W * H) begin
            errors++;
            $display("FAIL frame_done: got count=%0d at=%0d want 1 at %0d", fd, fd_at, W * H);
        end
    endtask

    task automatic test_arith();
        int dsum[6] = '{-24, -24, 5000, 7, 8, int'(32'h8000_0000)};
        bit dabs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [7:0] dexp[6] = '{8'h00, 8'h01, 8'hFF, 8'h00, 8'h01, 8'hFF};
        int n = 0, want, s;
        apply_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 2 * W + 2 + 26 + 6; i++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL arith_extra: got px=%h want none", out_pixel);
                end else begin
                    want = exp_q.pop_front();
                    if ({out_last, out_pixel} !== 9'(want)) begin
                        errors++;
                        $display("FAIL arith_model #%0d: got %h want %h", n, {out_last, out_pixel}, 9'(want));
                    end
                end
                if (n < 6) begin
                    checks++;
                    if (out_pixel !== dexp[n]) begin
                        errors++;
                        $display("FAIL arith_directed #%0d: got %h want %h", n, out_pixel, dexp[n]);
                    end
                end
                n++;
            end
            if (i < 2 * W + 2) feed(0, 1'b0);
            else if (i < 2 * W + 8) feed(dsum[i - (2 * W + 2)], dabs[i - (2 * W + 2)]);
            else if (i < 2 * W + 28) begin
                s = (i % 2) ? int'($urandom) : int'($urandom_range(0, 8000)) - 4000;
                feed(s, 1'($urandom_range(0, 1)));
            end else idle();
        end
        checks++;
        if (n !== 26) begin
            errors++;
            $display("FAIL arith_count: got %0d want 26", n);
        end
    endtask

    task automatic test_latency();
        apply_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 2 * W + 2; i++) begin @(negedge clk); feed(0, 1'b0); end
        @(negedge clk); feed(100, 1'b0);
        @(negedge clk); idle();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL lat_n: got v=%b want 0", out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL lat_n1: got v=%b want 0", out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_pixel !== 8'd6 || fifo_level !== 4'd1) begin
            errors++;
            $display("FAIL lat_n2: got v=%b px=%h lvl=%0d want 1 06 1", out_valid, out_pixel, fifo_level);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_pixel !== 8'h00) begin
            errors++;
            $display("FAIL lat_empty: got v=%b px=%h want 0 00", out_valid, out_pixel);
        end
    endtask

    task automatic test_backpressure();
        int n = 0, want;
        apply_reset();
        for (int i = 0; i < 2 * W + 2; i++) begin @(negedge clk); feed(0, 1'b0); end
        for (int k = 0; k < 10; k++) begin @(negedge clk); feed(16 * (k + 1) + 3, 1'b0); end
        repeat (4) begin @(negedge clk); idle(); end
        checks++;
        if (fifo_level !== 4'd8 || overflow !== 1'b1 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_full: got lvl=%0d ov=%b v=%b want 8 1 1", fifo_level, overflow, out_valid);
        end
        while (exp_q.size() > D) void'(exp_q.pop_back());
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({out_last, out_pixel} !== 9'(exp_q[0])) begin
                errors++;
                $display("FAIL bp_stall #%0d: got %h want %h", k, {out_last, out_pixel}, 9'(exp_q[0]));
            end
        end
        out_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (out_valid && out_ready) begin
                checks++;
                want = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                if (want < 0 || {out_last, out_pixel} !== 9'(want)) begin
                    errors++;
                    $display("FAIL bp_drain #%0d: got %h want %0h", n, {out_last, out_pixel}, want);
                end
                n++;
            end
            @(negedge clk);
        end
        checks++;
        if (n !== D || out_valid !== 1'b0 || fifo_level !== 4'd0 || out_pixel !== 8'h00 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL bp_after: got n=%0d v=%b lvl=%0d px=%h ov=%b want 8 0 0 00 1",
                     n, out_valid, fifo_level, out_pixel, overflow);
        end
    endtask

    task automatic test_full_pop();
        int n = 0, want;
        apply_reset();
        for (int i = 0; i < 2 * W + 2; i++) begin @(negedge clk); feed(0, 1'b0); end
        for (int k = 0; k < 9; k++) begin @(negedge clk); feed(16 * (k + 1) + 3, 1'b0); end
        @(negedge clk); idle();
        checks++;
        if (fifo_level !== 4'd7) begin
            errors++;
            $display("FAIL fp_level7: got %0d want 7", fifo_level);
        end
        @(negedge clk);
        checks++;
        if (fifo_level !== 4'd8) begin
            errors++;
            $display("FAIL fp_level8: got %0d want 8", fifo_level);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 14; k++) begin
            if (k == 1) begin
                checks++;
                if (fifo_level !== 4'd8 || overflow !== 1'b0) begin
                    errors++;
                    $display("FAIL fp_push_pop: got lvl=%0d ov=%b want 8 0", fifo_level, overflow);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                want = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                if (want < 0 || {out_last, out_pixel} !== 9'(want)) begin
                    errors++;
                    $display("FAIL fp_drain #%0d: got %h want %0h", n, {out_last, out_pixel}, want);
                end
                n++;
            end
            @(negedge clk);
        end
        checks++;
        if (n !== 9 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL fp_after: got n=%0d ov=%b want 9 0", n, overflow);
        end
    endtask

    task automatic test_reset_midframe();
        int n = 0, fd = 0, want;
        apply_reset();
        for (int i = 0; i < 10 * W + 5; i++) begin
            @(negedge clk); feed(int'($urandom_range(0, 4000)), 1'b0);
        end
        @(negedge clk); idle();
        checks++;
        if (out_valid !== 1'b1 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre: got v=%b ov=%b want 1 1", out_valid, overflow);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, out_pixel, out_last, overflow, fifo_level} !== '0) begin
            errors++;
            $display("FAIL mid_async: got v=%b px=%h l=%b ov=%b lvl=%0d want all 0",
                     out_valid, out_pixel, out_last, overflow, fifo_level);
        end
        @(negedge clk); rst = 1'b0;
        exp_q.delete(); model_idx = 0;
        out_ready = 1'b1;
        for (int i = 0; i < W * H + 8; i++) begin
            @(negedge clk);
            if (frame_done === 1'b1) fd++;
            if (out_valid && out_ready) begin
                checks++;
                want = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                if (want < 0 || {out_last, out_pixel} !== 9'(want)) begin
                    errors++;
                    $display("FAIL mid_frame #%0d: got %h want %0h", n, {out_last, out_pixel}, want);
                end
                n++;
            end
            if (i < W * H) feed(int'($urandom_range(0, 8191)) - 4096, 1'($urandom_range(0, 1)));
            else idle();
        end
        checks++;
        if (n !== KEPT || exp_q.size() !== 0 || fd !== 1) begin
            errors++;
            $display("FAIL mid_totals: got n=%0d left=%0d fd=%0d want %0d 0 1", n, exp_q.size(), fd, KEPT);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sum = '0; abs_en = 1'b0; out_ready = 1'b0;
        test_reset();
        test_full_frame();
        test_arith();
        test_latency();
        test_backpressure();
        test_full_pop();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
